// File: rtl/addsub96_pkg.sv
// Shared types and constants for the addsub96 host bridge.
// Defining ADDSUB96_STATUS_EN adds a fourth status word to every result.
package addsub96_pkg;

  typedef enum logic [1:0] {LOAD, WAIT, SEND} state_e;

  localparam int A_WORDS = 3;
  localparam int OPND_W  = 95;
  localparam int SUM_W   = 96;
  localparam int WORD_W  = 32;

`ifdef ADDSUB96_STATUS_EN
  localparam int RES_WORDS = 4;
`else
  localparam int RES_WORDS = 3;
`endif

  // Word k of the outgoing result; word 3 only exists when status is enabled.
  function automatic logic [WORD_W-1:0] res_word(input logic [SUM_W-1:0] res,
                                                 input logic op,
                                                 input logic [1:0] k);
    case (k)
      2'd0:    res_word = res[31:0];
      2'd1:    res_word = res[63:32];
      2'd2:    res_word = res[95:64];
      default: res_word = {30'b0, op, res[95]};
    endcase
  endfunction

endpackage

// File: rtl/addsub96_host_if.sv
// Word-serial valid/ready bridge in front of the fixed-latency addsub96 core.
// ADDSUB96_STATUS_EN (see addsub96_pkg) appends a status word to each result.
module addsub96_host_if
  import addsub96_pkg::*;
#(
  parameter int LAT = 3
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                S_VALID,
  output logic                S_READY,
  input  logic [WORD_W-1:0]   S_DATA,
  input  logic                S_OP,
  output logic                M_VALID,
  input  logic                M_READY,
  output logic [WORD_W-1:0]   M_DATA,
  output logic                M_LAST,
  output logic [OPND_W-1:0]   AIN,
  output logic [OPND_W-1:0]   BIN,
  output logic                ADD_SUB,
  input  logic [SUM_W-1:0]    SUM_OUT
);

  state_e              state_q, state_d;
  logic [2:0]          wcnt_q, wcnt_d;
  logic [3:0]          lcnt_q, lcnt_d;
  logic [1:0]          kcnt_q, kcnt_d;
  logic [OPND_W-1:0]   ain_q, ain_d, bin_q, bin_d;
  logic                add_sub_q, add_sub_d;
  logic [SUM_W-1:0]    res_q, res_d;
  logic                s_ready_q, s_ready_d;
  logic                m_valid_q, m_valid_d;
  logic                m_last_q, m_last_d;
  logic [WORD_W-1:0]   m_data_q, m_data_d;

  logic                in_fire, out_fire, bsel;
  logic [2:0]          idx;
  logic [OPND_W-1:0]   opnd;

  assign in_fire  = S_VALID & s_ready_q;
  assign out_fire = m_valid_q & M_READY;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= LOAD;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (in_fire && wcnt_q == 3'd5) state_d = WAIT;
      WAIT:    if (lcnt_q == 4'd0) state_d = SEND;
      SEND:    if (out_fire && m_last_q) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // Words 0..2 fill A and 3..5 fill B; only word 0 carries the op select.
  always_comb begin
    wcnt_d    = wcnt_q;
    lcnt_d    = lcnt_q;
    kcnt_d    = kcnt_q;
    ain_d     = ain_q;
    bin_d     = bin_q;
    add_sub_d = add_sub_q;
    res_d     = res_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    m_data_d  = m_data_q;
    bsel      = (wcnt_q >= 3'(A_WORDS));
    idx       = bsel ? (wcnt_q - 3'(A_WORDS)) : wcnt_q;
    opnd      = bsel ? bin_q : ain_q;
    case (state_q)
      LOAD: begin
        if (in_fire) begin
          case (idx)
            3'd0:    opnd[31:0]  = S_DATA;
            3'd1:    opnd[63:32] = S_DATA;
            default: opnd[94:64] = S_DATA[30:0];
          endcase
          if (bsel) bin_d = opnd;
          else      ain_d = opnd;
          if (wcnt_q == 3'd0) add_sub_d = S_OP;
          if (wcnt_q == 3'd5) begin
            wcnt_d = 3'd0;
            lcnt_d = 4'(LAT - 1);
          end else begin
            wcnt_d = wcnt_q + 3'd1;
          end
        end
      end
      WAIT: begin
        if (lcnt_q == 4'd0) begin
          res_d     = SUM_OUT;
          m_valid_d = 1'b1;
          m_last_d  = 1'b0;
          m_data_d  = res_word(SUM_OUT, add_sub_q, 2'd0);
          kcnt_d    = 2'd0;
        end else begin
          lcnt_d = lcnt_q - 4'd1;
        end
      end
      SEND: begin
        if (out_fire) begin
          if (m_last_q) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            m_data_d  = '0;
            kcnt_d    = 2'd0;
          end else begin
            kcnt_d   = kcnt_q + 2'd1;
            m_data_d = res_word(res_q, add_sub_q, kcnt_q + 2'd1);
            m_last_d = ((kcnt_q + 2'd1) == 2'(RES_WORDS - 1));
          end
        end
      end
      default: ;
    endcase
    s_ready_d = (state_d == LOAD);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wcnt_q    <= '0;
      lcnt_q    <= '0;
      kcnt_q    <= '0;
      ain_q     <= '0;
      bin_q     <= '0;
      add_sub_q <= 1'b0;
      res_q     <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
    end else begin
      wcnt_q    <= wcnt_d;
      lcnt_q    <= lcnt_d;
      kcnt_q    <= kcnt_d;
      ain_q     <= ain_d;
      bin_q     <= bin_d;
      add_sub_q <= add_sub_d;
      res_q     <= res_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_data_q  <= m_data_d;
    end
  end

  assign S_READY = s_ready_q;
  assign M_VALID = m_valid_q;
  assign M_LAST  = m_last_q;
  assign M_DATA  = m_data_q;
  assign AIN     = ain_q;
  assign BIN     = bin_q;
  assign ADD_SUB = add_sub_q;

endmodule

// File: tb/tb_addsub96_host_if.sv
// Directed bench for addsub96_host_if with a behavioural fixed-latency core.
// Build with +define+ADDSUB96_STATUS_EN to also cover the status word.
module tb_addsub96_host_if;

  localparam int LAT = 3;
`ifdef ADDSUB96_STATUS_EN
  localparam int NWORDS = 4;
`else
  localparam int NWORDS = 3;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        S_VALID = 1'b0;
  logic        S_READY;
  logic [31:0] S_DATA = '0;
  logic        S_OP = 1'b0;
  logic        M_VALID;
  logic        M_READY = 1'b1;
  logic [31:0] M_DATA;
  logic        M_LAST;
  logic [94:0] AIN;
  logic [94:0] BIN;
  logic        ADD_SUB;
  logic [95:0] SUM_OUT;

  int errors = 0;
  int checks = 0;

  addsub96_host_if #(.LAT(LAT)) dut (
    .CLK(CLK), .RST(RST),
    .S_VALID(S_VALID), .S_READY(S_READY), .S_DATA(S_DATA), .S_OP(S_OP),
    .M_VALID(M_VALID), .M_READY(M_READY), .M_DATA(M_DATA), .M_LAST(M_LAST),
    .AIN(AIN), .BIN(BIN), .ADD_SUB(ADD_SUB), .SUM_OUT(SUM_OUT)
  );

  always #5 CLK = ~CLK;

  // Core model: result usable at the LAT-th edge after the operands change.
  logic [95:0] coreNow;
  logic [95:0] corePipe [0:LAT-2];
  assign coreNow = ADD_SUB ? ({1'b0, AIN} - {1'b0, BIN}) : ({1'b0, AIN} + {1'b0, BIN});
  always @(posedge CLK) begin
    corePipe[0] <= coreNow;
    for (int i = 1; i < LAT - 1; i++) corePipe[i] <= corePipe[i-1];
  end
  assign SUM_OUT = corePipe[LAT-2];

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] d, input logic op);
    int n = 0;
    @(negedge CLK);
    S_VALID = 1'b1;
    S_DATA  = d;
    S_OP    = op;
    while (!S_READY && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) checkOutput("s_ready_timeout", S_READY, 1);
    @(posedge CLK);
    #1;
    S_VALID = 1'b0;
  endtask

  // Later words carry the inverted op so a late sample of S_OP is visible.
  task automatic sendOperands(input logic [94:0] a, input logic [94:0] b, input logic op,
                              input int gap, input logic junk);
    logic [31:0] w [6];
    w[0] = a[31:0];  w[1] = a[63:32]; w[2] = {junk, a[94:64]};
    w[3] = b[31:0];  w[4] = b[63:32]; w[5] = {junk, b[94:64]};
    for (int i = 0; i < 6; i++) begin
      repeat (gap) @(posedge CLK);
      applyStimulus(w[i], (i == 0) ? op : ~op);
    end
  endtask

  task automatic checkLatency();
    repeat (LAT - 1) @(posedge CLK);
    #1;
    checkOutput("lat_early", M_VALID, 0);
    checkOutput("wait_sready", S_READY, 0);
    @(posedge CLK);
    #1;
    checkOutput("lat_rise", M_VALID, 1);
  endtask

  task automatic recvResult(input string tag, input logic [95:0] res, input logic op, input int stallWord);
    logic [31:0] exp;
    for (int k = 0; k < NWORDS; k++) begin
      int n = 0;
      case (k)
        0:       exp = res[31:0];
        1:       exp = res[63:32];
        2:       exp = res[95:64];
        default: exp = {30'b0, op, res[95]};
      endcase
      while (!M_VALID && n < 50) begin
        @(posedge CLK);
        #1;
        n++;
      end
      if (n >= 50) checkOutput({tag, "_m_valid_timeout"}, M_VALID, 1);
      checkOutput({tag, "_data"}, M_DATA, exp);
      checkOutput({tag, "_last"}, M_LAST, (k == NWORDS - 1));
      if (k == stallWord) begin
        M_READY = 1'b0;
        repeat (5) begin
          @(posedge CLK);
          #1;
          checkOutput("stall_data", M_DATA, exp);
          checkOutput("stall_valid", M_VALID, 1);
          checkOutput("stall_sready", S_READY, 0);
        end
        M_READY = 1'b1;
      end
      @(posedge CLK);
      #1;
    end
    checkOutput({tag, "_sready_after"}, S_READY, 1);
    checkOutput({tag, "_mvalid_after"}, M_VALID, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("rst_sready", S_READY, 0);
    checkOutput("rst_mvalid", M_VALID, 0);
    checkOutput("rst_mlast", M_LAST, 0);
    checkOutput("rst_mdata", M_DATA, 0);
    checkOutput("rst_ain", AIN, 0);
    checkOutput("rst_bin", BIN, 0);
    checkOutput("rst_addsub", ADD_SUB, 0);
    @(negedge CLK);
    RST = 1'b0;

    // Basic add: 10 + 0x1_0000_0000_0009
    sendOperands(95'd10, 95'h1_0000_0000_0009, 1'b0, 0, 1'b0);
    checkOutput("add_ain", AIN, 95'd10);
    checkOutput("add_bin", BIN, 95'h1_0000_0000_0009);
    checkOutput("add_op", ADD_SUB, 0);
    checkLatency();
    recvResult("add", 96'h00000000_00010000_00000013, 1'b0, -1);

    // Subtract with the same operands
    sendOperands(95'd10, 95'h1_0000_0000_0009, 1'b1, 0, 1'b0);
    checkOutput("sub_op", ADD_SUB, 1);
    checkLatency();
    recvResult("sub", 96'hFFFFFFFF_FFFF0000_00000001, 1'b1, -1);

    // Output backpressure on word 1
    sendOperands(95'd10, 95'h1_0000_0000_0009, 1'b0, 0, 1'b0);
    recvResult("bp", 96'h00000000_00010000_00000013, 1'b0, 1);

    // Input gaps with bit 31 of each top word set
    sendOperands(95'd10, 95'h1_0000_0000_0009, 1'b0, 2, 1'b1);
    checkOutput("gap_ain_top", AIN[94:64], 0);
    checkOutput("gap_bin_top", BIN[94:64], 0);
    recvResult("gap", 96'h00000000_00010000_00000013, 1'b0, -1);

    // Reset after word 3 of a subtract transaction
    applyStimulus(32'd7, 1'b1);
    applyStimulus(32'd0, 1'b0);
    applyStimulus(32'd0, 1'b0);
    applyStimulus(32'd9, 1'b0);
    checkOutput("pre_rst_op", ADD_SUB, 1);
    RST = 1'b1;
    #2;
    checkOutput("mid_rst_sready", S_READY, 0);
    checkOutput("mid_rst_mvalid", M_VALID, 0);
    checkOutput("mid_rst_mlast", M_LAST, 0);
    checkOutput("mid_rst_mdata", M_DATA, 0);
    checkOutput("mid_rst_ain", AIN, 0);
    checkOutput("mid_rst_bin", BIN, 0);
    checkOutput("mid_rst_addsub", ADD_SUB, 0);
    @(negedge CLK);
    RST = 1'b0;
    sendOperands(95'd5, 95'd3, 1'b0, 0, 1'b0);
    checkLatency();
    recvResult("post_rst", 96'd8, 1'b0, -1);

    // Max + max sets the carry bit; status word (if built) reports it
    sendOperands({95{1'b1}}, {95{1'b1}}, 1'b0, 0, 1'b0);
    recvResult("max", 96'hFFFFFFFF_FFFFFFFF_FFFFFFFE, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
